// File: rtl/pipeline_if_pkg.sv
// Shared types and constants for the RV32 instruction-fetch stage.
package pipeline_if_pkg;

    localparam int IF_STATE_WIDTH = 2;

    typedef enum logic [IF_STATE_WIDTH-1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2,
        IF_HOLD = 2'd3
    } if_state_e;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pipeline_if_skid_buf.sv
// One-entry {data, pc} buffer that catches a fetched instruction while decode stalls.
module if_skid_buf
    import pipeline_if_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        drain,
    input  logic        flush,
    input  logic [31:0] load_data,
    input  logic [31:0] load_pc,
    output logic [31:0] data,
    output logic [31:0] pc,
    output logic        valid
);

    logic [31:0] data_r;
    logic [31:0] pc_r;
    logic        valid_r;

    // Entry storage; flush wins over load so a redirect never leaves stale state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r  <= INST_NOP;
            pc_r    <= 32'h0000_0000;
            valid_r <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (load) begin
            data_r  <= load_data;
            pc_r    <= load_pc;
            valid_r <= 1'b1;
        end else if (drain) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign data  = data_r;
    assign pc    = pc_r;
    assign valid = valid_r;

endmodule

// File: rtl/pipeline_if.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time from imem and
// hands {inst, pc} to decode; later stages may redirect and flush it.
module pipeline_if
    import pipeline_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        id_ready
);

    if_state_e   state_r;
    if_state_e   state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] pending_pc_r;
    logic        discard_r;
    logic        discard_s;
    logic        pending_load_s;
    logic        out_load_s;
    logic        skid_load_s;
    logic        skid_drain_s;
    logic        flush_s;
    logic [31:0] inst_r;
    logic [31:0] inst_pc_r;
    logic        inst_valid_r;
    logic [31:0] skid_data_s;
    logic [31:0] skid_pc_s;
    logic        skid_valid_s;

    // A redirect is ignored in IDLE, where nothing is in flight yet
    assign flush_s = redirect_valid && (state_r != IF_IDLE);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IF_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state, PC, discard and slot control
    always_comb begin
        state_s        = state_r;
        pc_s           = pc_r;
        discard_s      = discard_r;
        pending_load_s = 1'b0;
        out_load_s     = 1'b0;
        skid_load_s    = 1'b0;
        skid_drain_s   = 1'b0;
        if (state_r == IF_IDLE) begin
            state_s = IF_REQ;
        end else if (redirect_valid) begin
            pc_s = word_align(redirect_pc);
            case (state_r)
                IF_REQ: begin
                    if (imem_req_ready) begin
                        state_s   = IF_WAIT;
                        discard_s = 1'b1;
                    end else begin
                        state_s = IF_REQ;
                    end
                end
                IF_WAIT: begin
                    if (imem_resp_valid) begin
                        state_s   = IF_REQ;
                        discard_s = 1'b0;
                    end else begin
                        state_s   = IF_WAIT;
                        discard_s = 1'b1;
                    end
                end
                IF_HOLD: state_s = IF_REQ;
                default: state_s = IF_REQ;
            endcase
        end else begin
            case (state_r)
                IF_REQ: begin
                    if (imem_req_ready) begin
                        pending_load_s = 1'b1;
                        state_s        = IF_WAIT;
                    end else begin
                        state_s = IF_REQ;
                    end
                end
                IF_WAIT: begin
                    if (!imem_resp_valid) begin
                        state_s = IF_WAIT;
                    end else if (discard_r) begin
                        discard_s = 1'b0;
                        state_s   = IF_REQ;
                    end else begin
                        pc_s = pending_pc_r + 32'd4;
                        if (!inst_valid_r || id_ready) begin
                            out_load_s = 1'b1;
                            state_s    = IF_REQ;
                        end else begin
                            skid_load_s = 1'b1;
                            state_s     = IF_HOLD;
                        end
                    end
                end
                IF_HOLD: begin
                    if (id_ready) begin
                        skid_drain_s = 1'b1;
                        state_s      = IF_REQ;
                    end else begin
                        state_s = IF_HOLD;
                    end
                end
                default: state_s = IF_IDLE;
            endcase
        end
    end

    // PC, in-flight fetch address and discard flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r         <= RESET_PC;
            pending_pc_r <= RESET_PC;
            discard_r    <= 1'b0;
        end else begin
            pc_r      <= pc_s;
            discard_r <= discard_s;
            if (pending_load_s) begin
                pending_pc_r <= pc_r;
            end else begin
                pending_pc_r <= pending_pc_r;
            end
        end
    end

    // Output slot toward decode; a fresh response outranks the skid entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_r       <= INST_NOP;
            inst_pc_r    <= 32'h0000_0000;
            inst_valid_r <= 1'b0;
        end else if (flush_s) begin
            inst_valid_r <= 1'b0;
        end else if (out_load_s) begin
            inst_r       <= imem_resp_data;
            inst_pc_r    <= pending_pc_r;
            inst_valid_r <= 1'b1;
        end else if (skid_drain_s) begin
            inst_r       <= skid_data_s;
            inst_pc_r    <= skid_pc_s;
            inst_valid_r <= skid_valid_s;
        end else if (inst_valid_r && id_ready) begin
            inst_valid_r <= 1'b0;
        end else begin
            inst_valid_r <= inst_valid_r;
        end
    end

    if_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load_s),
        .drain     (skid_drain_s),
        .flush     (flush_s),
        .load_data (imem_resp_data),
        .load_pc   (pending_pc_r),
        .data      (skid_data_s),
        .pc        (skid_pc_s),
        .valid     (skid_valid_s)
    );

    assign imem_req_valid = (state_r == IF_REQ);
    assign imem_req_addr  = pc_r;
    assign inst           = inst_r;
    assign inst_pc        = inst_pc_r;
    assign inst_valid     = inst_valid_r;

endmodule

// File: tb/tb_pipeline_if.sv
// Directed bench for pipeline_if: memory model, in-order delivery scoreboard and
// hand-computed expectations for each scenario.
module tb_pipeline_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        id_ready;

    always #5 clk = ~clk;

    pipeline_if #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_valid      (inst_valid),
        .id_ready        (id_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    logic        st_req_ready;
    logic        st_id_ready;
    logic        st_redir;
    logic [31:0] st_redir_pc;
    int          mem_lat;

    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    logic [31:0] exp_q[$];
    logic [31:0] next_fetch;
    logic        prev_stall;
    logic [31:0] prev_addr;
    logic        prev_redir;

    logic [31:0] req_addr_log[$];
    int          req_cyc_log[$];
    logic [31:0] dlv_pc_log[$];
    logic [31:0] dlv_inst_log[$];
    int          dlv_cyc_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs and memory at negedge, then check and update the model
    task automatic tick();
        logic acc;
        logic hs;
        @(negedge clk);
        cyc++;
        imem_req_ready = st_req_ready;
        id_ready       = st_id_ready;
        redirect_valid = st_redir;
        redirect_pc    = st_redir_pc;
        if (mem_busy && mem_cnt == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mem_addr);
            mem_busy        = 1'b0;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'hDEAD_BEEF;
            if (mem_busy) mem_cnt--;
        end
        #1;
        acc = imem_req_valid && imem_req_ready;
        hs  = inst_valid && id_ready && !redirect_valid;
        if (imem_req_valid) chk("req_align", {30'd0, imem_req_addr[1:0]}, 32'd0);
        if (prev_stall) begin
            chk("req_hold_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("req_hold_addr", imem_req_addr, prev_addr);
        end
        if (prev_redir) chk("flush_out", {31'd0, inst_valid}, 32'd0);
        if (hs) begin
            dlv_pc_log.push_back(inst_pc);
            dlv_inst_log.push_back(inst);
            dlv_cyc_log.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL dlv_extra: got pc %h, expected no transfer", inst_pc);
            end else begin
                chk("dlv_pc", inst_pc, exp_q[0]);
                chk("dlv_inst", inst, mem_word(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
        if (acc) begin
            req_addr_log.push_back(imem_req_addr);
            req_cyc_log.push_back(cyc);
            chk("req_addr", imem_req_addr, next_fetch);
            chk("one_outstanding", {31'd0, mem_busy}, 32'd0);
            mem_busy = 1'b1;
            mem_addr = imem_req_addr;
            mem_cnt  = mem_lat - 1;
            if (!redirect_valid) begin
                exp_q.push_back(imem_req_addr);
                next_fetch = imem_req_addr + 32'd4;
            end
        end
        if (redirect_valid) begin
            exp_q.delete();
            next_fetch = {redirect_pc[31:2], 2'b00};
        end
        prev_stall = imem_req_valid && !imem_req_ready && !redirect_valid;
        prev_addr  = imem_req_addr;
        prev_redir = redirect_valid;
        st_redir   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        id_ready        = 1'b0;
        st_req_ready    = 1'b1;
        st_id_ready     = 1'b1;
        st_redir        = 1'b0;
        st_redir_pc     = 32'h0;
        mem_lat         = 1;
        mem_busy        = 1'b0;
        mem_cnt         = 0;
        mem_addr        = 32'h0;
        exp_q.delete();
        next_fetch      = 32'h0;
        prev_stall      = 1'b0;
        prev_redir      = 1'b0;
        prev_addr       = 32'h0;
        req_addr_log.delete();
        req_cyc_log.delete();
        dlv_pc_log.delete();
        dlv_inst_log.delete();
        dlv_cyc_log.delete();
        cyc = 0;
        @(negedge clk);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0000_0000);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_inst_pc", inst_pc, 32'h0000_0000);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_no_req", {31'd0, imem_req_valid}, 32'd0);
    endtask

    task automatic wait_dlv(input int n, input int budget, input string name);
        for (int i = 0; i < budget && dlv_pc_log.size() < n; i++) tick();
        chk(name, dlv_pc_log.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;

        // Streaming with 1-cycle memory and decode always ready
        do_reset();
        tick();
        chk("t1_first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        wait_dlv(3, 40, "t1_dlv_count");
        chk("t1_req0", req_addr_log[0], 32'h0);
        chk("t1_req1", req_addr_log[1], 32'h4);
        chk("t1_req2", req_addr_log[2], 32'h8);
        chk("t1_req0_cyc", req_cyc_log[0], 32'd1);
        chk("t1_req_gap1", req_cyc_log[1] - req_cyc_log[0], 32'd2);
        chk("t1_req_gap2", req_cyc_log[2] - req_cyc_log[1], 32'd2);
        chk("t1_dlv_gap", dlv_cyc_log[1] - dlv_cyc_log[0], 32'd2);
        chk("t1_pc0", dlv_pc_log[0], 32'h0);
        chk("t1_pc1", dlv_pc_log[1], 32'h4);
        chk("t1_pc2", dlv_pc_log[2], 32'h8);
        chk("t1_inst0", dlv_inst_log[0], 32'd0);
        chk("t1_inst1", dlv_inst_log[1], 32'd1);
        chk("t1_inst2", dlv_inst_log[2], 32'd2);

        // Decode stalls: output holds PC 0, skid holds PC 4, no fetch in HOLD
        do_reset();
        st_id_ready = 1'b0;
        for (int i = 0; i < 20 && !inst_valid; i++) tick();
        chk("t2_first_valid", {31'd0, inst_valid}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t2_hold_valid", {31'd0, inst_valid}, 32'd1);
            chk("t2_hold_pc", inst_pc, 32'h0);
            chk("t2_no_req", req_addr_log.size(), 32'd2);
        end
        st_id_ready = 1'b1;
        wait_dlv(2, 10, "t2_dlv_count");
        chk("t2_pc0", dlv_pc_log[0], 32'h0);
        chk("t2_pc1", dlv_pc_log[1], 32'h4);
        chk("t2_back_to_back", dlv_cyc_log[1] - dlv_cyc_log[0], 32'd1);
        wait_dlv(3, 20, "t2_dlv_count3");
        chk("t2_pc2", dlv_pc_log[2], 32'h8);

        // Memory not ready for 3 cycles
        do_reset();
        st_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_stall_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("t3_stall_addr", imem_req_addr, 32'h0);
        end
        st_req_ready = 1'b1;
        wait_dlv(1, 10, "t3_dlv_count");
        chk("t3_pc0", dlv_pc_log[0], 32'h0);
        chk("t3_req_cyc", req_cyc_log[0], 32'd4);

        // Redirect while waiting on a slow response
        do_reset();
        mem_lat = 3;
        tick();
        st_redir    = 1'b1;
        st_redir_pc = 32'h0000_0103;
        tick();
        chk("t4_in_wait", {31'd0, imem_req_valid}, 32'd0);
        wait_dlv(1, 30, "t4_dlv_count");
        chk("t4_req1", req_addr_log[1], 32'h0000_0100);
        chk("t4_pc0", dlv_pc_log[0], 32'h0000_0100);
        chk("t4_inst0", dlv_inst_log[0], 32'h0000_0040);

        // Redirect in the response cycle
        do_reset();
        tick();
        st_redir    = 1'b1;
        st_redir_pc = 32'h0000_0200;
        tick();
        wait_dlv(1, 20, "t5a_dlv_count");
        chk("t5a_req1", req_addr_log[1], 32'h0000_0200);
        chk("t5a_pc0", dlv_pc_log[0], 32'h0000_0200);
        chk("t5a_inst0", dlv_inst_log[0], 32'h0000_0080);

        // Redirect in the request-accept cycle
        do_reset();
        st_redir    = 1'b1;
        st_redir_pc = 32'h0000_0300;
        tick();
        wait_dlv(1, 20, "t5b_dlv_count");
        chk("t5b_req0", req_addr_log[0], 32'h0);
        chk("t5b_req1", req_addr_log[1], 32'h0000_0300);
        chk("t5b_pc0", dlv_pc_log[0], 32'h0000_0300);

        // Redirect to the top word: PC wraps to zero
        do_reset();
        st_req_ready = 1'b0;
        st_redir     = 1'b1;
        st_redir_pc  = 32'hFFFF_FFFC;
        tick();
        st_req_ready = 1'b1;
        wait_dlv(2, 20, "t6_dlv_count");
        chk("t6_req0", req_addr_log[0], 32'hFFFF_FFFC);
        chk("t6_req1", req_addr_log[1], 32'h0000_0000);
        chk("t6_pc0", dlv_pc_log[0], 32'hFFFF_FFFC);
        chk("t6_inst0", dlv_inst_log[0], 32'h3FFF_FFFF);
        chk("t6_pc1", dlv_pc_log[1], 32'h0000_0000);
        chk("t6_inst1", dlv_inst_log[1], 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
